// File: rtl/mult_batch_sequencer.sv
// ============================================================================
// Module   : mult_batch_sequencer
// Brief    : Runs a batch of operand pairs through a shared multiplier and
//            stores the products in the result RAM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_batch_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     op_base_i,
    input  logic [ADDR_W-1:0]     res_base_i,
    input  logic [ADDR_W-1:0]     count_i,
    output logic [ADDR_W-1:0]     rd_addr_o,
    input  logic [DATA_W-1:0]     rd_data_i,
    output logic                  wr_en_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [2*DATA_W-1:0]   wr_data_o,
    output logic                  mult_start_o,
    output logic [DATA_W-1:0]     mult_a_o,
    output logic [DATA_W-1:0]     mult_b_o,
    input  logic                  mult_end_i,
    input  logic [2*DATA_W-1:0]   mult_result_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [3:0]            state_o
);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_READ_A       = 4'd1,
        S_READ_B       = 4'd2,
        S_CAPTURE_B    = 4'd3,
        S_INIT_CALC    = 4'd4,
        S_WAIT_CALC    = 4'd5,
        S_STORE        = 4'd6,
        S_NEXT         = 4'd7,
        S_END_CALC     = 4'd8,
        S_WAIT_RELEASE = 4'd9
    } state_t;

    localparam logic [ADDR_W-1:0] c_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_W-1:0]     r_op_base;
    logic [ADDR_W-1:0]     r_res_base;
    logic [ADDR_W-1:0]     r_count;
    logic [ADDR_W-1:0]     r_idx;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic [2*DATA_W-1:0]   r_prod;

    logic [ADDR_W-1:0]     w_addr_a;
    logic [ADDR_W-1:0]     w_addr_b;
    logic [ADDR_W-1:0]     w_res_addr;
    logic                  w_last;

    // Address arithmetic wraps naturally at ADDR_W bits.
    assign w_addr_a   = r_op_base + {r_idx[ADDR_W-2:0], 1'b0};
    assign w_addr_b   = w_addr_a + c_ONE;
    assign w_res_addr = r_res_base + r_idx;
    // r_count is never zero while pairs are being processed.
    assign w_last     = (r_idx == (r_count - c_ONE));

    always_comb begin
        w_next       = r_state;
        rd_addr_o    = r_rd_addr;
        wr_addr_o    = r_wr_addr;
        wr_en_o      = 1'b0;
        mult_start_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = (count_i != '0) ? S_READ_A : S_END_CALC;
                end
            end
            S_READ_A: begin
                rd_addr_o = w_addr_a;
                w_next    = S_READ_B;
            end
            S_READ_B: begin
                rd_addr_o = w_addr_b;
                w_next    = S_CAPTURE_B;
            end
            S_CAPTURE_B: w_next = S_INIT_CALC;
            S_INIT_CALC: begin
                mult_start_o = 1'b1;
                w_next       = S_WAIT_CALC;
            end
            S_WAIT_CALC: begin
                if (mult_end_i) begin
                    w_next = S_STORE;
                end
            end
            S_STORE: begin
                wr_en_o   = 1'b1;
                wr_addr_o = w_res_addr;
                w_next    = S_NEXT;
            end
            S_NEXT:      w_next = w_last ? S_END_CALC : S_READ_A;
            S_END_CALC:  w_next = S_WAIT_RELEASE;
            S_WAIT_RELEASE: begin
                if (!start_i) begin
                    w_next = S_IDLE;
                end
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_op_base  <= '0;
            r_res_base <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_rd_addr  <= '0;
            r_wr_addr  <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_prod     <= '0;
        end else begin
            r_state   <= w_next;
            r_rd_addr <= rd_addr_o;
            r_wr_addr <= wr_addr_o;
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (start_i && (count_i != '0)) begin
                        r_op_base  <= op_base_i;
                        r_res_base <= res_base_i;
                        r_count    <= count_i;
                    end
                end
                // The RAM returns data one cycle after the address is shown.
                S_READ_B:    r_a <= rd_data_i;
                S_CAPTURE_B: r_b <= rd_data_i;
                S_WAIT_CALC: begin
                    if (mult_end_i) begin
                        r_prod <= mult_result_i;
                    end
                end
                S_NEXT: begin
                    if (!w_last) begin
                        r_idx <= r_idx + c_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mult_a_o  = r_a;
    assign mult_b_o  = r_b;
    assign wr_data_o = r_prod;
    assign busy_o    = (r_state != S_IDLE) && (r_state != S_WAIT_RELEASE);
    assign done_o    = (r_state == S_WAIT_RELEASE);
    assign state_o   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mult_batch_sequencer.sv
// ============================================================================
// Module   : tb_mult_batch_sequencer
// Brief    : Scoreboard bench for mult_batch_sequencer with RAM/multiplier models.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_batch_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  op_base_i, res_base_i, count_i;
    logic [7:0]  rd_addr_o;
    logic [15:0] rd_data_i;
    logic        wr_en_o;
    logic [7:0]  wr_addr_o;
    logic [31:0] wr_data_o;
    logic        mult_start_o;
    logic [15:0] mult_a_o, mult_b_o;
    logic        mult_end_i;
    logic [31:0] mult_result_i;
    logic        busy_o, done_o;
    logic [3:0]  state_o;

    mult_batch_sequencer #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .op_base_i(op_base_i), .res_base_i(res_base_i), .count_i(count_i),
        .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .mult_start_o(mult_start_o), .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
        .mult_end_i(mult_end_i), .mult_result_i(mult_result_i),
        .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem [256];
    logic [7:0]  q_rd [$];
    logic [31:0] q_st [$];
    logic [39:0] q_wr [$];
    logic [15:0] cur_a = '0, cur_b = '0;
    int          mult_w = 1;
    bit          spurious = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand RAM: one-cycle synchronous read.
    initial begin
        logic [7:0] a;
        rd_data_i = '0;
        forever begin
            @(negedge clk_i);
            a = rd_addr_o;
            @(posedge clk_i);
            #1 rd_data_i = mem[a];
        end
    end

    // Multiplier: end flag in the W-th cycle after the start pulse; optional
    // spurious end flag injected during READ_B.
    initial begin
        logic [31:0] p;
        int          w;
        mult_end_i    = 1'b0;
        mult_result_i = '0;
        forever begin
            @(negedge clk_i);
            if (spurious && state_o == 4'd1) begin
                spurious = 1'b0;
                @(posedge clk_i);
                #1 mult_end_i = 1'b1;
                mult_result_i = 32'hDEAD_BEEF;
                @(posedge clk_i);
                #1 mult_end_i = 1'b0;
            end else if (mult_start_o) begin
                p = {16'h0, mult_a_o} * {16'h0, mult_b_o};
                w = mult_w;
                repeat (w) begin
                    @(posedge clk_i);
                    #1;
                end
                mult_end_i    = 1'b1;
                mult_result_i = p;
                @(posedge clk_i);
                #1 mult_end_i = 1'b0;
                mult_result_i = '0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [39:0] e;
        logic [31:0] s;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (state_o == 4'd1 || state_o == 4'd2) begin
                    if (q_rd.size() == 0) chk("rd_unexpected", 64'(rd_addr_o), 64'hFFFF);
                    else chk("rd_addr", 64'(rd_addr_o), 64'(q_rd.pop_front()));
                end
                if (mult_start_o) begin
                    if (q_st.size() == 0) chk("start_unexpected", 64'd1, 64'd0);
                    else begin
                        s = q_st.pop_front();
                        cur_a = s[31:16];
                        cur_b = s[15:0];
                        chk("start_ops", 64'({mult_a_o, mult_b_o}), 64'(s));
                    end
                end
                if (state_o == 4'd5) begin
                    chk("op_a_stable", 64'(mult_a_o), 64'(cur_a));
                    chk("op_b_stable", 64'(mult_b_o), 64'(cur_b));
                end
                if (wr_en_o) begin
                    if (q_wr.size() == 0) chk("wr_unexpected", 64'(wr_addr_o), 64'hFFFF);
                    else begin
                        e = q_wr.pop_front();
                        chk("wr_addr", 64'(wr_addr_o), 64'(e[39:32]));
                        chk("wr_data", 64'(wr_data_o), 64'(e[31:0]));
                    end
                end
            end
        end
    end

    task automatic push_pair(input logic [7:0] op, input logic [7:0] res, input logic [7:0] k,
                             input logic [15:0] a, input logic [15:0] b,
                             input logic [31:0] p, input bit full);
        logic [7:0] t;
        t = op + {k[6:0], 1'b0};
        mem[t]        = a;
        mem[t + 8'd1] = b;
        q_rd.push_back(t);
        q_rd.push_back(t + 8'd1);
        q_st.push_back({a, b});
        if (full) q_wr.push_back({res + k, p});
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_state"}, 64'(state_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_wr_en"}, 64'(wr_en_o), 64'd0);
        chk({tag, "_mstart"}, 64'(mult_start_o), 64'd0);
        chk({tag, "_addrs"}, 64'({rd_addr_o, wr_addr_o}), 64'd0);
        chk({tag, "_data"}, 64'({wr_data_o, mult_a_o, mult_b_o}), 64'd0);
    endtask

    task automatic check_queues(input string tag);
        chk({tag, "_rd_left"}, 64'(q_rd.size()), 64'd0);
        chk({tag, "_st_left"}, 64'(q_st.size()), 64'd0);
        chk({tag, "_wr_left"}, 64'(q_wr.size()), 64'd0);
    endtask

    task automatic run_batch(input string tag, input logic [7:0] op, input logic [7:0] res,
                             input logic [7:0] cnt, input int w);
        int k;
        mult_w = w;
        @(negedge clk_i);
        op_base_i  = op;
        res_base_i = res;
        count_i    = cnt;
        start_i    = 1'b1;
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (!busy_o && k < 5);
        chk({tag, "_busy_lat"}, 64'(k), 64'd1);
        k = 0;
        while (!done_o && k < 1000) begin
            @(negedge clk_i);
            k++;
        end
        chk({tag, "_batch_len"}, 64'(k), 64'(int'(cnt) * (6 + w) + 1));
        repeat (2) begin
            @(negedge clk_i);
            chk({tag, "_done_hold"}, 64'({done_o, busy_o, state_o}), 64'({1'b1, 1'b0, 4'd9}));
        end
        start_i = 1'b0;
        @(negedge clk_i);
        chk({tag, "_release"}, 64'({done_o, state_o}), 64'd0);
        check_queues(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_i = 1'b1; start_i = 1'b0;
        op_base_i = '0; res_base_i = '0; count_i = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        repeat (2) @(negedge clk_i);
        check_idle_outputs("reset");
        rst_i = 1'b0;

        // Single pair.
        push_pair(8'h10, 8'h40, 8'd0, 16'd3, 16'd5, 32'd15, 1'b1);
        run_batch("single", 8'h10, 8'h40, 8'd1, 1);

        // Three pairs including full-scale operands.
        push_pair(8'h20, 8'h50, 8'd0, 16'd2, 16'd7, 32'd14, 1'b1);
        push_pair(8'h20, 8'h50, 8'd1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1);
        push_pair(8'h20, 8'h50, 8'd2, 16'd0, 16'd9, 32'd0, 1'b1);
        run_batch("three", 8'h20, 8'h50, 8'd3, 2);

        // Address wrap-around.
        push_pair(8'hFE, 8'hFF, 8'd0, 16'd4, 16'd6, 32'h18, 1'b1);
        push_pair(8'hFE, 8'hFF, 8'd1, 16'h100, 16'h10, 32'h1000, 1'b1);
        run_batch("wrap", 8'hFE, 8'hFF, 8'd2, 1);

        // Zero count: no RAM or multiplier activity.
        run_batch("zero", 8'h33, 8'h44, 8'd0, 1);

        // Slow multiplier with a spurious end flag during READ_B.
        spurious = 1'b1;
        push_pair(8'h30, 8'h90, 8'd0, 16'hABCD, 16'd2, 32'h1579A, 1'b1);
        run_batch("slow", 8'h30, 8'h90, 8'd1, 10);

        // Reset during WAIT_CALC of the second of four pairs.
        push_pair(8'h60, 8'h80, 8'd0, 16'd1, 16'd1, 32'd1, 1'b1);
        push_pair(8'h60, 8'h80, 8'd1, 16'd2, 16'd3, 32'd6, 1'b0);
        mult_w = 3;
        @(negedge clk_i);
        op_base_i = 8'h60; res_base_i = 8'h80; count_i = 8'd4; start_i = 1'b1;
        k = 0;
        while (!(state_o == 4'd5 && q_st.size() == 0) && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        chk("abort_reached", 64'(k < 200), 64'd1);
        rst_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("abort");
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("abort_state", 64'(state_o), 64'd0);
        check_queues("abort");

        push_pair(8'h60, 8'h80, 8'd0, 16'd1, 16'd1, 32'd1, 1'b1);
        push_pair(8'h60, 8'h80, 8'd1, 16'd2, 16'd3, 32'd6, 1'b1);
        push_pair(8'h60, 8'h80, 8'd2, 16'h10, 16'h20, 32'h200, 1'b1);
        push_pair(8'h60, 8'h80, 8'd3, 16'h1234, 16'h10, 32'h12340, 1'b1);
        run_batch("rerun", 8'h60, 8'h80, 8'd4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_batch_sequencer.md
# mult_batch_sequencer

Sequences a batch of multiplications through the shared multiplier. On a start request it reads operand pairs from the operand RAM, launches the multiplier once per pair, waits for its end flag, and writes each product to the result RAM. It sits between the host control logic (start level, busy/done status) and the multiplier plus its two RAMs, and replaces per-operation manual control with one batch command.

## Interface
Parameters:
- ADDR_W, 8: address width of both RAMs.
- DATA_W, 16: operand width. Product width is 2*DATA_W.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  level request; a batch starts on its rising level seen in IDLE.
- op_base_i  in  ADDR_W  operand region base; sampled at start.
- res_base_i  in  ADDR_W  result region base; sampled at start.
- count_i  in  ADDR_W  number of pairs N; sampled at start.
- rd_addr_o  out  ADDR_W  operand RAM read address. The RAM has a synchronous read with 1-cycle latency.
- rd_data_i  in  DATA_W  operand RAM read data.
- wr_en_o  out  1  result RAM write strobe.
- wr_addr_o  out  ADDR_W  result RAM write address.
- wr_data_o  out  2*DATA_W  result RAM write data.
- mult_start_o  out  1  one-cycle multiplier start pulse.
- mult_a_o, mult_b_o  out  DATA_W  operands; held stable from INIT_CALC until the end flag.
- mult_end_i  in  1  multiplier end flag.
- mult_result_i  in  2*DATA_W  product; valid in the cycle mult_end_i is high.
- busy_o  out  1  high in every state except IDLE and WAIT_RELEASE.
- done_o  out  1  high in WAIT_RELEASE.
- state_o  out  4  current state encoding.

## Operation
- Memory layout: pair k uses A at op_base+2k and B at op_base+2k+1. The product goes to res_base+k. All address arithmetic is modulo 2^ADDR_W (wrap-around, no error).
- State encoding on state_o: IDLE=0, READ_A=1, READ_B=2, CAPTURE_B=3, INIT_CALC=4, WAIT_CALC=5, STORE=6, NEXT=7, END_CALC=8, WAIT_RELEASE=9. Any other value goes to IDLE next cycle.
- IDLE: idx is cleared.
  - start_i=1 and count_i≠0: latch op_base_i, res_base_i and count_i; go to READ_A.
  - start_i=1 and count_i=0: go to END_CALC. No RAM or multiplier activity occurs.
- READ_A: rd_addr_o = op_base+2·idx.
- READ_B: rd_addr_o = op_base+2·idx+1; capture rd_data_i into A.
- CAPTURE_B: capture rd_data_i into B.
- INIT_CALC: mult_start_o=1 for exactly this cycle.
- WAIT_CALC: stay while mult_end_i=0. When mult_end_i=1, capture mult_result_i and go to STORE. A mult_end_i seen in any other state is ignored.
- STORE: wr_en_o=1, wr_addr_o=res_base+idx, wr_data_o = captured product.
- NEXT: if idx = N−1 go to END_CALC; otherwise idx+1 and go to READ_A.
- END_CALC: go to WAIT_RELEASE on the next cycle.
- WAIT_RELEASE: hold done_o=1 while start_i=1. When start_i=0, go to IDLE. Holding start high therefore never restarts a batch.
- start_i is ignored while busy; dropping it mid-batch does not abort. Only rst_i aborts.
- When not being driven as specified above, wr_en_o and mult_start_o are 0, and rd_addr_o and wr_addr_o hold their last value.

## Timing
- Reset (any cycle, including mid-batch): next state IDLE, idx=0, internal A/B/product registers 0. All outputs read 0 in the cycle after reset: state_o=0, busy_o=0, done_o=0, wr_en_o=0, mult_start_o=0, addresses 0, data 0. A write or start pulse in flight is suppressed.
- Per pair: READ_A, READ_B, CAPTURE_B, INIT_CALC, W×WAIT_CALC, STORE, NEXT = 6+W cycles. W≥1 is the number of cycles up to and including the one where mult_end_i=1.
- Batch, from the first busy cycle to done_o rising: N·(6+W)+1 cycles. With N=0: 1 cycle (END_CALC), then done_o.
- busy_o rises in the cycle after start_i is sampled. done_o rises the cycle after END_CALC.

## Test plan
- Single pair, op RAM[0x10]=3 and [0x11]=5, op_base=0x10, res_base=0x40, N=1, multiplier end 1 cycle after start -> exactly one mult_start_o pulse with a=3, b=5; write 15 to 0x40; done_o 8 cycles after busy_o rises.
- N=3 with pairs (2,7), (0xFFFF,0xFFFF), (0,9) -> writes 14, 0xFFFE0001 and 0 to res_base..res_base+2, in order; exactly 3 start pulses.
- Wrap: op_base=0xFE, res_base=0xFF, N=2 -> reads at 0xFE, 0xFF, 0x00, 0x01; writes at 0xFF then 0x00.
- count_i=0 -> no rd/wr/mult_start activity; done_o high 2 cycles after start; it stays high while start_i=1, then IDLE one cycle after start_i falls.
- Slow multiplier (end after 10 cycles), plus a spurious mult_end_i during READ_B -> the spurious end is ignored; WAIT_CALC lasts 10 cycles; operands stay stable throughout.
- rst_i asserted during WAIT_CALC of pair 2 of 4 -> state_o=0 and all outputs 0 the next cycle; no further writes; a fresh start then runs from pair 0.
